// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared constants and types for the pipeline memory stage
// Rev 1.0
// ============================================================================
package pipe_pkg;

    localparam int MEM_LAT_MAX = 15;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] ins;
        logic [4:0]  writereg;
        logic        mem_to_reg;
        logic        reg_write;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// data_mem : synchronous word RAM, one write port, one registered read port
// Rev 1.0
// ============================================================================
module data_mem
    import pipe_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : memory-access stage with branch resolve, multi-cycle data memory
//             and the MEM/WB pipeline register
// Rev 1.0
// ============================================================================
module mem_stage
    import pipe_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int MEM_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bPCMEM,
    input  logic        ALUzeroMEM,
    input  logic [31:0] ALUresultMEM,
    input  logic [31:0] insMEM,
    input  logic [31:0] dmemdata,
    input  logic [4:0]  writeregMEM,
    input  logic        MemtoRegMEM,
    input  logic        RegWriteMEM,
    input  logic        beqMEM,
    input  logic        bneMEM,
    input  logic        MemReadMEM,
    input  logic        MemWriteMEM,
    output logic        PCSrc,
    output logic [31:0] branchPC,
    output logic        mem_stall,
    output logic [31:0] readdataWB,
    output logic [31:0] ALUresultWB,
    output logic [31:0] insWB,
    output logic [4:0]  writeregWB,
    output logic        MemtoRegWB,
    output logic        RegWriteWB,
    output logic        misaligned_err
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
    localparam logic       SINGLE = (MEM_LAT == 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
            $error("mem_stage: MEM_LAT out of range");
        end
    endgenerate

    logic                  access;
    logic                  aligned;
    logic [DEPTH_LOG2-1:0] index;
    logic                  stall;
    logic                  complete;

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    memwb_t     wb_q, wb_d;
    logic       mis_q, mis_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{ALUresultMEM[31:DEPTH_LOG2+2]};

    assign access   = MemReadMEM | MemWriteMEM;
    assign aligned  = (ALUresultMEM[1:0] == 2'b00);
    assign index    = ALUresultMEM[DEPTH_LOG2+1:2];
    assign PCSrc    = (beqMEM & ALUzeroMEM) | (bneMEM & ~ALUzeroMEM);
    assign branchPC = bPCMEM;

    // The first cycle of a multi-cycle access stalls in IDLE; WAIT counts the rest down.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && aligned) begin
                    if (SINGLE) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Gated so the stall drops the instant reset asserts, even with an access held.
    assign mem_stall = stall & reset;

    assign mis_d = (state_q == ST_IDLE) & access & ~aligned;

    always_comb begin
        wb_d = MEMWB_BUBBLE;
        if (!stall) begin
            wb_d.alu_result = ALUresultMEM;
            wb_d.ins        = insMEM;
            wb_d.writereg   = writeregMEM;
            wb_d.mem_to_reg = MemtoRegMEM;
            wb_d.reg_write  = RegWriteMEM & ~mis_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wb_q    <= MEMWB_BUBBLE;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
            mis_q   <= mis_d;
        end
    end

    data_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_data_mem (
        .clk   (clk),
        .reset (reset),
        .we    (complete & MemWriteMEM & reset),
        .waddr (index),
        .wdata (dmemdata),
        .re    (complete & MemReadMEM),
        .raddr (index),
        .rdata (readdataWB)
    );

    assign ALUresultWB    = wb_q.alu_result;
    assign insWB          = wb_q.ins;
    assign writeregWB     = wb_q.writereg;
    assign MemtoRegWB     = wb_q.mem_to_reg;
    assign RegWriteWB     = wb_q.reg_write;
    assign misaligned_err = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_stage : self-checking bench; instances with MEM_LAT = 1, 2 and 4
// Rev 1.0
// ============================================================================
module tb_mem_stage;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] bpc_i [N];
    logic [31:0] alu_i [N];
    logic [31:0] ins_i [N];
    logic [31:0] wd_i  [N];
    logic [4:0]  wr_i  [N];
    logic        zero_i[N];
    logic        m2r_i [N];
    logic        rw_i  [N];
    logic        beq_i [N];
    logic        bne_i [N];
    logic        mr_i  [N];
    logic        mw_i  [N];

    logic        pcsrc_o[N];
    logic [31:0] bpc_o  [N];
    logic        stall_o[N];
    logic [31:0] rd_o   [N];
    logic [31:0] alu_o  [N];
    logic [31:0] ins_o  [N];
    logic [4:0]  wr_o   [N];
    logic        m2r_o  [N];
    logic        rw_o   [N];
    logic        mis_o  [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            mem_stage #(
                .DEPTH_LOG2 (8),
                .MEM_LAT    ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
            ) u_dut (
                .clk            (clk),
                .reset          (rst_n),
                .bPCMEM         (bpc_i[g]),
                .ALUzeroMEM     (zero_i[g]),
                .ALUresultMEM   (alu_i[g]),
                .insMEM         (ins_i[g]),
                .dmemdata       (wd_i[g]),
                .writeregMEM    (wr_i[g]),
                .MemtoRegMEM    (m2r_i[g]),
                .RegWriteMEM    (rw_i[g]),
                .beqMEM         (beq_i[g]),
                .bneMEM         (bne_i[g]),
                .MemReadMEM     (mr_i[g]),
                .MemWriteMEM    (mw_i[g]),
                .PCSrc          (pcsrc_o[g]),
                .branchPC       (bpc_o[g]),
                .mem_stall      (stall_o[g]),
                .readdataWB     (rd_o[g]),
                .ALUresultWB    (alu_o[g]),
                .insWB          (ins_o[g]),
                .writeregWB     (wr_o[g]),
                .MemtoRegWB     (m2r_o[g]),
                .RegWriteWB     (rw_o[g]),
                .misaligned_err (mis_o[g])
            );
        end
    endgenerate

    // Expected outputs per instance, plus a word-level picture of each memory.
    logic [31:0] e_rd [N];
    bit          e_rd_known [N];
    logic [31:0] e_alu[N];
    logic [31:0] e_ins[N];
    logic [4:0]  e_wr [N];
    logic        e_m2r[N];
    logic        e_rw [N];
    logic        e_mis[N];
    logic        e_stall[N];
    logic        e_pcsrc[N];
    logic [31:0] e_bpc[N];
    logic [31:0] mdat [N][256];
    bit          mval [N][256];

    int checks = 0;
    int failures = 0;
    int act = 1;
    bit cmp_en = 1'b0;
    int stall_seen = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] req);
        checks++;
        if (actual !== req) begin
            failures++;
            $display("FAIL %s inst=%0d actual=0x%08h required=0x%08h t=%0t", nm, act, actual, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_stall",      32'(stall_o[act]), 32'(e_stall[act]));
            chk("PCSrc",          32'(pcsrc_o[act]), 32'(e_pcsrc[act]));
            chk("branchPC",       bpc_o[act],        e_bpc[act]);
            chk("ALUresultWB",    alu_o[act],        e_alu[act]);
            chk("insWB",          ins_o[act],        e_ins[act]);
            chk("writeregWB",     32'(wr_o[act]),    32'(e_wr[act]));
            chk("MemtoRegWB",     32'(m2r_o[act]),   32'(e_m2r[act]));
            chk("RegWriteWB",     32'(rw_o[act]),    32'(e_rw[act]));
            chk("misaligned_err", 32'(mis_o[act]),   32'(e_mis[act]));
            if (e_rd_known[act]) begin
                chk("readdataWB", rd_o[act], e_rd[act]);
            end
            if (stall_o[act]) begin
                stall_seen++;
            end
        end
    end

    task automatic bubble(input int k);
        e_alu[k] = '0; e_ins[k] = '0; e_wr[k] = '0;
        e_m2r[k] = 1'b0; e_rw[k] = 1'b0; e_mis[k] = 1'b0;
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            bubble(j);
            e_stall[j]    = 1'b0;
            e_rd[j]       = '0;
            e_rd_known[j] = 1'b1;
        end
    endtask

    task automatic drive(input int k, input logic mr, input logic mw, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] ins, input logic [4:0] wr,
                         input logic m2r, input logic rw, input logic beq, input logic bne,
                         input logic z, input logic [31:0] bpc);
        mr_i[k] = mr; mw_i[k] = mw; alu_i[k] = alu; wd_i[k] = wd; ins_i[k] = ins;
        wr_i[k] = wr; m2r_i[k] = m2r; rw_i[k] = rw; beq_i[k] = beq; bne_i[k] = bne;
        zero_i[k] = z; bpc_i[k] = bpc;
        e_pcsrc[k] = (beq & z) | (bne & ~z);
        e_bpc[k]   = bpc;
    endtask

    // One instruction occupies LAT cycles if it is an aligned access, else one.
    task automatic issue(input int k, input logic mr, input logic mw, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] ins, input logic [4:0] wr,
                         input logic m2r, input logic rw, input logic beq, input logic bne,
                         input logic z, input logic [31:0] bpc);
        bit acc, al, mis;
        int occ, idx;
        acc = mr | mw;
        al  = (alu[1:0] == 2'b00);
        mis = acc && !al;
        occ = (acc && al) ? lat_of(k) : 1;
        idx = int'(alu[9:2]);
        drive(k, mr, mw, alu, wd, ins, wr, m2r, rw, beq, bne, z, bpc);
        for (int c = 0; c < occ; c++) begin
            e_stall[k] = (c != occ - 1);
            @(posedge clk); #1;
            if (c != occ - 1) begin
                bubble(k);
            end else begin
                e_alu[k] = alu; e_ins[k] = ins; e_wr[k] = wr; e_m2r[k] = m2r;
                e_rw[k]  = rw & !mis;
                e_mis[k] = mis;
                if (acc && al && mw) begin
                    mdat[k][idx] = wd;
                    mval[k][idx] = 1'b1;
                end
                if (acc && al && mr) begin
                    e_rd[k]       = mdat[k][idx];
                    e_rd_known[k] = mval[k][idx];
                end
            end
        end
    endtask

    task automatic st(input int k, input logic [31:0] addr, input logic [31:0] data);
        issue(k, 1'b0, 1'b1, addr, data, 32'hAC0A0000 | addr, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic ld(input int k, input logic [31:0] addr, input logic [4:0] wr);
        issue(k, 1'b1, 1'b0, addr, 32'h0, 32'h8C000000 | {11'd0, wr, 16'd0}, wr, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic idle(input int k);
        issue(k, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog inst=%0d actual=timeout required=finish", act);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int j = 0; j < N; j++) begin
            drive(j, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            for (int w = 0; w < 256; w++) begin
                mdat[j][w] = '0;
                mval[j][w] = 1'b0;
            end
        end
        model_reset();
        act = 1;
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pass-through and a known value for the reset-with-store case.
        issue(1, 1'b0, 1'b0, 32'h00001234, 32'h0, 32'h00431020, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("lit_passthru_alu", alu_o[1], 32'h00001234);
        st(1, 32'h8, 32'h5555AAAA);

        // Reset held with a store presented: nothing written, no stall, WB cleared.
        drive(1, 1'b0, 1'b1, 32'h8, 32'hBAD0BAD0, 32'hAC0A0008, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #1 chk("lit_reset_stall", 32'(stall_o[1]), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        ld(1, 32'h8, 5'd7);
        chk("lit_reset_nowrite", rd_o[1], 32'h5555AAAA);

        // MEM_LAT=2 store then dependent load.
        stall_seen = 0;
        st(1, 32'h10, 32'hDEADBEEF);
        chk("lit_stall_lat2", 32'(stall_seen), 32'd1);
        chk("lit_model_word4", mdat[1][4], 32'hDEADBEEF);
        ld(1, 32'h10, 5'd9);
        chk("lit_load_lat2", rd_o[1], 32'hDEADBEEF);
        chk("lit_m2r_load", 32'(m2r_o[1]), 32'h1);

        // Branch resolution.
        issue(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10220003, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
        chk("lit_beq_taken", 32'(pcsrc_o[1]), 32'h1);
        chk("lit_branchpc", bpc_o[1], 32'h40);
        issue(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h14220003, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
        chk("lit_bne_not_taken", 32'(pcsrc_o[1]), 32'h0);
        issue(1, 1'b0, 1'b0, 32'h5, 32'h0, 32'h14220004, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h84);

        // Misaligned store and load: no stall, pulse, RegWrite suppressed.
        stall_seen = 0;
        st(1, 32'h13, 32'h0BADF00D);
        chk("lit_mis_pulse", 32'(mis_o[1]), 32'h1);
        issue(1, 1'b1, 1'b0, 32'h12, 32'h0, 32'h8C0B0012, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("lit_mis_regwrite", 32'(rw_o[1]), 32'h0);
        idle(1);
        chk("lit_mis_cleared", 32'(mis_o[1]), 32'h0);
        chk("lit_mis_nostall", 32'(stall_seen), 32'd0);
        ld(1, 32'h10, 5'd9);
        chk("lit_mis_mem_unchanged", rd_o[1], 32'hDEADBEEF);

        // Address wrap modulo 256 words.
        st(1, 32'h400, 32'hCAFEF00D);
        ld(1, 32'h0, 5'd4);
        chk("lit_wrap", rd_o[1], 32'hCAFEF00D);
        idle(1);

        // MEM_LAT=4 load latency.
        act = 2;
        idle(2);
        st(2, 32'h20, 32'h11111111);
        stall_seen = 0;
        ld(2, 32'h20, 5'd5);
        chk("lit_stall_lat4", 32'(stall_seen), 32'd3);
        chk("lit_load_lat4", rd_o[2], 32'h11111111);

        // MEM_LAT=1: no stalls, store visible to the very next load.
        act = 0;
        idle(0);
        stall_seen = 0;
        st(0, 32'h30, 32'hA5A5C3C3);
        ld(0, 32'h30, 5'd2);
        chk("lit_stall_lat1", 32'(stall_seen), 32'd0);
        chk("lit_load_lat1", rd_o[0], 32'hA5A5C3C3);
        idle(0);

        // Reset in the middle of a MEM_LAT=4 store drops the store.
        act = 2;
        idle(2);
        drive(2, 1'b0, 1'b1, 32'h20, 32'h22222222, 32'hAC0A0020, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        e_stall[2] = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            bubble(2);
        end
        rst_n = 1'b0;
        model_reset();
        #1 chk("lit_midwait_stall", 32'(stall_o[2]), 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ld(2, 32'h20, 5'd6);
        chk("lit_midwait_mem", rd_o[2], 32'h11111111);
        idle(2);
        idle(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
